// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of seven-segment digits sharing one hex2seg.
// Double-buffered display word: a new word is committed only at the end of a full scan.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 50000,
  parameter bit          LZS    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dots,
  output logic [3:0]            hex_num,
  output logic                  hex_dot,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(DIV);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   act_dots_q, act_dots_d, pend_dots_q, pend_dots_d;
  logic                pend_full_q, pend_full_d;
  logic [3:0]          hex_num_q, hex_num_d;
  logic                hex_dot_q, hex_dot_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                frame_done_q, frame_done_d;

  logic            tick, last_idx, frame_end, xfer, suppress;
  logic [IdxW-1:0] msd;
  logic [3:0]      cur_nib;
  logic            cur_dot;

  assign in_ready = ~pend_full_q & ~rst;
  assign xfer     = in_valid & in_ready;

  // Most significant non-zero digit of the displayed word; 0 when the word is all zero.
  always_comb begin
    msd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (act_data_q[4*i +: 4] != 4'h0) msd = IdxW'(i);
    end
  end

  assign cur_nib  = act_data_q[4*idx_q +: 4];
  assign cur_dot  = act_dots_q[idx_q];
  assign suppress = LZS && (idx_q > msd) && !cur_dot;

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    act_data_d  = act_data_q;
    act_dots_d  = act_dots_q;
    pend_data_d = pend_data_q;
    pend_dots_d = pend_dots_q;
    pend_full_d = pend_full_q;

    tick      = en && (cnt_q == CntW'(DIV - 1));
    last_idx  = (idx_q == IdxW'(DIGITS - 1));
    frame_end = tick && last_idx;

    if (en) cnt_d = tick ? '0 : cnt_q + CntW'(1);
    if (tick) idx_d = last_idx ? '0 : idx_q + IdxW'(1);

    // A transfer and a commit never coincide: in_ready is low while pending is full.
    if (xfer) begin
      pend_data_d = in_data;
      pend_dots_d = in_dots;
      pend_full_d = 1'b1;
    end
    if (frame_end && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_dots_d  = pend_dots_q;
      pend_full_d = 1'b0;
    end

    frame_done_d = frame_end;

    if (!en) begin
      dig_sel_d = '1;
      hex_num_d = suppress ? 4'h0 : cur_nib;
      hex_dot_d = 1'b0;
    end else if (suppress) begin
      dig_sel_d = '1;
      hex_num_d = 4'h0;
      hex_dot_d = 1'b0;
    end else begin
      dig_sel_d = ~(DIGITS'(1) << idx_q);
      hex_num_d = cur_nib;
      hex_dot_d = cur_dot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dots_q   <= '0;
      pend_data_q  <= '0;
      pend_dots_q  <= '0;
      pend_full_q  <= 1'b0;
      hex_num_q    <= 4'h0;
      hex_dot_q    <= 1'b0;
      dig_sel_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dots_q   <= act_dots_d;
      pend_data_q  <= pend_data_d;
      pend_dots_q  <= pend_dots_d;
      pend_full_q  <= pend_full_d;
      hex_num_q    <= hex_num_d;
      hex_dot_q    <= hex_dot_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hex_num    = hex_num_q;
  assign hex_dot    = hex_dot_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (8 digits, 4 clocks per slot, suppression on) against a
// scan-position reference model: one frame is 32 positions, digit = position / 4.
module tb_seg_scan_ctrl;

  localparam int N   = 8;
  localparam int D   = 4;
  localparam int FRM = N * D;

  logic          clk = 1'b0;
  logic          rst, en, in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [7:0]    in_dots;
  logic [3:0]    hex_num;
  logic          hex_dot;
  logic [7:0]    dig_sel;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          pos;
  logic [31:0] m_act, m_pend;
  logic [7:0]  m_actd, m_pendd;
  bit          m_full;

  seg_scan_ctrl #(.DIGITS(N), .DIV(D), .LZS(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dots    (in_dots),
    .hex_num    (hex_num),
    .hex_dot    (hex_dot),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (pos %0d)", tag, got, exp, pos);
    end
  endtask

  function automatic int msd_of(input logic [31:0] w);
    for (int i = N - 1; i >= 0; i--) if (((w >> (4 * i)) & 32'hF) != 0) return i;
    return 0;
  endfunction

  // One clock: drive inputs, check in_ready, clock, check registered outputs, advance model.
  task automatic step(input logic v, input logic [31:0] d, input logic [7:0] m,
                      input logic e, input logic r);
    int          dig;
    bit          show, fe, xf;
    logic [7:0]  e_sel;
    logic [3:0]  e_num;
    logic        e_dot, e_done;
    in_valid = v; in_data = d; in_dots = m; en = e; rst = r;
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, (!r && !m_full)});
    dig  = pos / D;
    show = (dig == 0) || (dig <= msd_of(m_act)) || m_actd[dig];
    fe   = e && (pos == FRM - 1);
    if (r) begin
      e_sel = 8'hFF; e_num = 4'h0; e_dot = 1'b0; e_done = 1'b0;
    end else begin
      e_sel  = (e && show) ? ~(8'h01 << dig) : 8'hFF;
      e_num  = show ? 4'((m_act >> (4 * dig)) & 32'hF) : 4'h0;
      e_dot  = e && show && m_actd[dig];
      e_done = fe;
    end
    @(posedge clk);
    #1;
    check("dig_sel", {24'b0, dig_sel}, {24'b0, e_sel});
    check("hex_dot", {31'b0, hex_dot}, {31'b0, e_dot});
    check("frame_done", {31'b0, frame_done}, {31'b0, e_done});
    if (r || e) check("hex_num", {28'b0, hex_num}, {28'b0, e_num});
    if (r) begin
      pos = 0; m_act = '0; m_actd = '0; m_pend = '0; m_pendd = '0; m_full = 0;
    end else begin
      xf = v && !m_full;
      if (fe && m_full) begin
        m_act = m_pend; m_actd = m_pendd; m_full = 0;
      end
      if (xf) begin
        m_pend = d; m_pendd = m; m_full = 1;
      end
      if (e) pos = (pos + 1) % FRM;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, $urandom, $urandom, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  rm;
    pos = 0; m_act = '0; m_actd = '0; m_pend = '0; m_pendd = '0; m_full = 0;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; in_dots = '0;

    // Reset, then idle scan with an empty display
    step(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    idle(70);

    // Single word offered mid-frame
    step(1'b1, 32'h1234_5678, 8'h00, 1'b1, 1'b0);
    idle(2 * FRM);

    // Back-to-back words: B stalls until A commits
    idle(5);
    step(1'b1, 32'h0000_00AB, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2 * FRM + 8; k++) step(1'b1, 32'hCD00_0EF1, 8'h00, 1'b1, 1'b0);
    idle(FRM);

    // All-zero word with a dot on digit 4
    step(1'b1, 32'h0, 8'h10, 1'b1, 1'b0);
    idle(2 * FRM);

    // Drop en in the middle of digit 3's slot, then resume
    for (int k = 0; k < 2 * FRM && !(pos == 3 * D + 1); k++) idle(1);
    check("reached_idx3", pos, 3 * D + 1);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    idle(FRM);

    // Reset mid-frame with a word pending
    idle(7);
    step(1'b1, 32'h8765_4321, 8'h0F, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    idle(FRM + 4);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      rd = $urandom >> (4 * $urandom_range(0, 7));
      rm = 8'($urandom & $urandom & $urandom);
      step(1'($urandom_range(0, 9) == 0), rd, rm, ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
